// File: rtl/rc5_pkg.sv
// Shared types and helpers for the parametrised RC5 engine.
// Rotates work on a 64-bit carrier so one pair of functions serves every word width.
package rc5_pkg;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   localparam logic ENC = 1'b0;
   localparam logic DEC = 1'b1;

   localparam int MAX_W = 64;
   typedef logic [MAX_W-1:0] word_t;

   function automatic word_t wmask(input int w);
      return (w >= MAX_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
   endfunction

   // sh must be below w; the bits shifted past w are masked off
   function automatic word_t rotl(input word_t x, input int sh, input int w);
      word_t v;
      v = x & wmask(w);
      return ((v << sh) | (v >> (w - sh))) & wmask(w);
   endfunction

   function automatic word_t rotr(input word_t x, input int sh, input int w);
      word_t v;
      v = x & wmask(w);
      return ((v >> sh) | (v << (w - sh))) & wmask(w);
   endfunction

endpackage

// File: rtl/rc5_core_param_round.sv
// One combinational RC5 round, encrypt or decrypt; the final decrypt round
// also strips the S[0]/S[1] pre-whitening.
module rc5_round
   import rc5_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] s_even,
   input  logic [W-1:0] s_odd,
   input  logic [W-1:0] s_zero,
   input  logic [W-1:0] s_one,
   input  logic         final_dec,
   output logic [W-1:0] a_nxt,
   output logic [W-1:0] b_nxt
);

   localparam int LW = $clog2(W);

   logic [W-1:0] ea, eb, da, db;

   always_comb begin
      ea = W'(rotl(word_t'(a ^ b), int'(b[LW-1:0]), W)) + s_even;
      eb = W'(rotl(word_t'(b ^ ea), int'(ea[LW-1:0]), W)) + s_odd;
      db = W'(rotr(word_t'(b - s_odd), int'(a[LW-1:0]), W)) ^ a;
      da = W'(rotr(word_t'(a - s_even), int'(db[LW-1:0]), W)) ^ db;
      if (final_dec) begin
         db = db - s_one;
         da = da - s_zero;
      end
      a_nxt = (mode == DEC) ? da : ea;
      b_nxt = (mode == DEC) ? db : eb;
   end

endmodule

// File: rtl/rc5_core_param.sv
// Iterative RC5-W/R engine: one round per clock, loadable S table,
// valid/ready on both sides, per-block encrypt/decrypt.
module rc5_core_param
   import rc5_pkg::*;
#(
   parameter  int W    = 16,
   parameter  int R    = 12,
   localparam int KA_W = $clog2(2*R+2)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            key_we,
   input  logic [KA_W-1:0] key_addr,
   input  logic [W-1:0]    key_wdata,
   output logic            key_err,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_mode,
   input  logic [2*W-1:0]  in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*W-1:0]  out_data,
   output logic            out_mode,
   output logic            busy
);

   localparam int              NK    = 2*R + 2;
   localparam logic [KA_W-1:0] KMAX  = KA_W'(NK - 1);
   localparam logic [KA_W-1:0] RLAST = KA_W'(R);
   localparam logic [KA_W-1:0] RONE  = KA_W'(1);

   state_t                state;
   logic [NK-1:0][W-1:0]  s_tab;
   logic [W-1:0]          a_r, b_r, a_nxt, b_nxt, s0_acc, s1_acc, a_ld, b_ld;
   logic                  mode_r;
   logic [KA_W-1:0]       rnd, idx_e, idx_o;
   logic                  accept, key_ok, key_wr, last, final_dec;

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign accept   = in_valid && in_ready;
   assign key_ok   = (state != ROUND) && (key_addr <= KMAX);
   assign key_wr   = key_we && key_ok;

   // a write landing on the accept edge must already feed the pre-whitening
   assign s0_acc = (key_wr && key_addr == '0)   ? key_wdata : s_tab[0];
   assign s1_acc = (key_wr && key_addr == RONE) ? key_wdata : s_tab[1];
   assign a_ld   = (in_mode == DEC) ? in_data[W-1:0]   : in_data[W-1:0] + s0_acc;
   assign b_ld   = (in_mode == DEC) ? in_data[2*W-1:W] : in_data[2*W-1:W] + s1_acc;

   assign idx_e     = rnd << 1;
   assign idx_o     = idx_e | RONE;
   assign final_dec = (mode_r == DEC) && (rnd == RONE);
   assign last      = (mode_r == ENC) ? (rnd == RLAST) : final_dec;

   rc5_round #(.W(W)) u_round (
      .mode      (mode_r),
      .a         (a_r),
      .b         (b_r),
      .s_even    (s_tab[idx_e]),
      .s_odd     (s_tab[idx_o]),
      .s_zero    (s_tab[0]),
      .s_one     (s_tab[1]),
      .final_dec (final_dec),
      .a_nxt     (a_nxt),
      .b_nxt     (b_nxt)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         s_tab     <= '0;
         a_r       <= '0;
         b_r       <= '0;
         mode_r    <= ENC;
         rnd       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mode  <= ENC;
         busy      <= 1'b0;
         key_err   <= 1'b0;
      end else begin
         key_err <= key_we && !key_ok;
         if (key_wr) s_tab[key_addr] <= key_wdata;
         case (state)
            ROUND: begin
               a_r <= a_nxt;
               b_r <= b_nxt;
               rnd <= (mode_r == ENC) ? rnd + RONE : rnd - RONE;
               if (last) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  out_data  <= {b_nxt, a_nxt};
                  out_mode  <= mode_r;
               end
            end
            IDLE, DONE: begin
               if (state == DONE && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
               // in DONE an accept implies the result was consumed on this edge
               if (accept) begin
                  state  <= ROUND;
                  busy   <= 1'b1;
                  a_r    <= a_ld;
                  b_r    <= b_ld;
                  mode_r <= in_mode;
                  rnd    <= (in_mode == DEC) ? RLAST : RONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rc5_core_param.sv
// Bench for rc5_core_param: a cycle-level expectation model of the engine
// checked every cycle, plus directed literal checks on an R=1 instance.
module tb_rc5_core_param;

   localparam int R = 12;

   logic        clk, reset;
   logic        key_we, key_err, in_valid, in_ready, in_mode;
   logic [4:0]  key_addr;
   logic [15:0] key_wdata;
   logic [31:0] in_data, out_data;
   logic        out_valid, out_ready, out_mode, busy;

   logic        key_we1, key_err1, in_valid1, in_ready1, in_mode1;
   logic [1:0]  key_addr1;
   logic [15:0] key_wdata1;
   logic [31:0] in_data1, out_data1;
   logic        out_valid1, out_ready1, out_mode1, busy1;

   int total = 0;
   int bad   = 0;

   rc5_core_param #(.W(16), .R(R)) dut (
      .clock(clk), .reset(reset), .key_we(key_we), .key_addr(key_addr),
      .key_wdata(key_wdata), .key_err(key_err), .in_valid(in_valid),
      .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_mode(out_mode), .busy(busy));

   rc5_core_param #(.W(16), .R(1)) dut1 (
      .clock(clk), .reset(reset), .key_we(key_we1), .key_addr(key_addr1),
      .key_wdata(key_wdata1), .key_err(key_err1), .in_valid(in_valid1),
      .in_ready(in_ready1), .in_mode(in_mode1), .in_data(in_data1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_mode(out_mode1), .busy(busy1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] rl(input logic [15:0] x, input logic [3:0] n);
      logic [31:0] t;
      t = {x, x} << n;
      return t[31:16];
   endfunction

   function automatic logic [31:0] model_enc(input logic [31:0] pt, input logic [15:0] s [0:25],
                                             input int nr);
      logic [15:0] a, b;
      a = pt[15:0] + s[0];
      b = pt[31:16] + s[1];
      for (int r = 1; r <= nr; r++) begin
         a = rl(a ^ b, b[3:0]) + s[2*r];
         b = rl(b ^ a, a[3:0]) + s[2*r+1];
      end
      return {b, a};
   endfunction

   // expectation model: mk mirrors the key table, a block in flight is
   // described only by its accept edge number and its expected result
   logic [15:0] mk [0:25];
   logic [31:0] dec_pt, exp_out;
   logic        exp_mode, have_blk, kerr_exp, seen_rst, in_round, out_pend;
   int          e_cnt = 0;
   int          ea = 0;

   initial begin
      have_blk = 1'b0; kerr_exp = 1'b0; seen_rst = 1'b0;
      exp_out = '0; exp_mode = 1'b0;
      for (int k = 0; k < 26; k++) mk[k] = '0;
   end

   always begin
      @(negedge clk);
      #4;
      in_round = have_blk && (e_cnt - ea) < R;
      out_pend = have_blk && !in_round;
      if (seen_rst) begin
         chk("mon_busy", 64'(busy), 64'(in_round));
         chk("mon_out_valid", 64'(out_valid), 64'(out_pend));
         chk("mon_in_ready", 64'(in_ready), 64'(!in_round && (!out_pend || out_ready)));
         chk("mon_key_err", 64'(key_err), 64'(kerr_exp));
         if (out_pend) begin
            chk("mon_out_data", 64'(out_data), 64'(exp_out));
            chk("mon_out_mode", 64'(out_mode), 64'(exp_mode));
         end
      end
      if (reset) begin
         have_blk = 1'b0;
         kerr_exp = 1'b0;
         seen_rst = 1'b1;
         for (int k = 0; k < 26; k++) mk[k] = '0;
      end else if (seen_rst) begin
         kerr_exp = 1'b0;
         if (key_we) begin
            if (!in_round && int'(key_addr) <= 2*R+1) mk[key_addr] = key_wdata;
            else kerr_exp = 1'b1;
         end
         if (out_pend && out_ready) have_blk = 1'b0;
         if (in_valid && !in_round && (!out_pend || out_ready)) begin
            have_blk = 1'b1;
            ea       = e_cnt + 1;
            exp_out  = in_mode ? dec_pt : model_enc(in_data, mk, R);
            exp_mode = in_mode;
         end
      end
      e_cnt++;
   end

   task automatic send(input logic md, input logic [31:0] d, input logic [31:0] pt, input bit rr);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_mode = md; in_data = d; dec_pt = pt;
      if (rr) out_ready = 1'($urandom_range(0, 1));
      #4;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         if (rr) out_ready = 1'($urandom_range(0, 1));
         #4;
         n++;
      end
      if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
   endtask

   task automatic drain();
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   task automatic key_write(input logic [4:0] adr, input logic [15:0] v);
      @(negedge clk);
      key_we = 1'b1; key_addr = adr; key_wdata = v;
      @(negedge clk);
      key_we = 1'b0;
   endtask

   logic [15:0] s_pin [0:25];
   logic [15:0] s_zero [0:25];
   logic [31:0] pats [0:3];
   logic [31:0] pt;
   int          n;

   initial begin
      reset = 1'b1;
      key_we = 0; key_addr = 0; key_wdata = 0; in_valid = 0; in_mode = 0; in_data = 0;
      out_ready = 1; dec_pt = 0;
      key_we1 = 0; key_addr1 = 0; key_wdata1 = 0; in_valid1 = 0; in_mode1 = 0; in_data1 = 0;
      out_ready1 = 1;
      for (int k = 0; k < 26; k++) begin
         s_pin[k] = (k < 4) ? 16'(k + 1) : 16'h0;
         s_zero[k] = 16'h0;
      end
      pats[0] = 32'h0000_0000; pats[1] = 32'hFFFF_FFFF;
      pats[2] = 32'hAAAA_5555; pats[3] = 32'h5555_AAAA;

      chk("model_pin_r1", 64'(model_enc(32'h0, s_pin, 1)), 64'h800A_000F);
      chk("model_pin_zero", 64'(model_enc(32'h0, s_zero, R)), 64'h0);

      repeat (3) @(negedge clk);
      reset = 1'b0;
      #4;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst1_busy", 64'(busy1), 64'd0);
      chk("rst1_key_err", 64'(key_err1), 64'd0);

      // R=1 vector from the hand-worked example
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         key_we1 = 1'b1; key_addr1 = 2'(k); key_wdata1 = 16'(k + 1);
      end
      @(negedge clk);
      key_we1 = 1'b0; in_valid1 = 1'b1; in_mode1 = 1'b0; in_data1 = 32'h0;
      @(negedge clk);
      in_valid1 = 1'b0;
      #4;
      chk("r1_busy", 64'(busy1), 64'd1);
      chk("r1_not_yet", 64'(out_valid1), 64'd0);
      @(negedge clk);
      #4;
      chk("r1_enc_valid", 64'(out_valid1), 64'd1);
      chk("r1_enc_data", 64'(out_data1), 64'h800A_000F);
      chk("r1_enc_mode", 64'(out_mode1), 64'd0);
      @(negedge clk);
      in_valid1 = 1'b1; in_mode1 = 1'b1; in_data1 = 32'h800A_000F;
      @(negedge clk);
      in_valid1 = 1'b0;
      @(negedge clk);
      #4;
      chk("r1_dec_valid", 64'(out_valid1), 64'd1);
      chk("r1_dec_data", 64'(out_data1), 64'h0);
      chk("r1_dec_mode", 64'(out_mode1), 64'd1);

      // random key table, then encrypt/decrypt round trips
      for (int k = 0; k < 26; k++) key_write(5'(k), 16'($urandom));
      for (int i = 0; i < 104; i++) begin
         pt = (i < 4) ? pats[i] : $urandom;
         send(1'b0, pt, 32'h0, i[0]);
         send(1'b1, model_enc(pt, mk, R), pt, i[0]);
      end
      drain();

      // back-pressure, then a new block on the handshake edge
      out_ready = 1'b0;
      send(1'b0, 32'h1234_5678, 32'h0, 1'b0);
      @(negedge clk);
      in_mode = 1'b0; in_data = 32'hCAFE_F00D;
      repeat (32) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      chk("nobubble_busy", 64'(busy), 64'd1);
      chk("nobubble_out_valid", 64'(out_valid), 64'd0);
      drain();

      // key write while rounds are running
      send(1'b0, 32'h0BAD_BEEF, 32'h0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0; key_we = 1'b1; key_addr = 5'd3; key_wdata = ~mk[3];
      @(negedge clk);
      key_we = 1'b0;
      #4;
      chk("kerr_round", 64'(key_err), 64'd1);
      @(negedge clk);
      #4;
      chk("kerr_pulse_end", 64'(key_err), 64'd0);
      drain();
      send(1'b0, 32'h1357_9BDF, 32'h0, 1'b0);
      drain();

      // out-of-range index while idle
      key_write(5'd26, 16'h1234);
      #4;
      chk("kerr_range", 64'(key_err), 64'd1);
      send(1'b0, 32'h2468_ACE0, 32'h0, 1'b0);
      drain();

      // write and accept on the same edge: block sees the new S[0]
      @(negedge clk);
      key_we = 1'b1; key_addr = 5'd0; key_wdata = 16'($urandom);
      in_valid = 1'b1; in_mode = 1'b0; in_data = $urandom;
      @(negedge clk);
      key_we = 1'b0; in_valid = 1'b0;
      drain();

      // reset on the fifth round edge
      send(1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #4;
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
      send(1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      #4;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         #4;
         n++;
      end
      chk("rst_keys_cleared", 64'(out_data), 64'h0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rc5_core_param.md
Name: rc5_core_param

Overview:
- Parametrised iterative RC5-W/R block cipher engine; successor to the fixed 16-bit encrypt-only core.
- Adds selectable word width, round count, encrypt/decrypt mode per block, a loadable expanded-key table and valid/ready handshakes on input and output.
- Sits between the key-expansion unit, which writes the S table, and the datapath block stream.
- Processes one full RC5 round per clock.

Parameters:
- W, 16, half-block word width; power of 2 in {8,16,32,64}; block is 2W bits.
- R, 12, number of rounds; must be >= 1.
- KA_W, $clog2(2*R+2), key-table address width (derived, not overridden).

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- key_we  in  1  key-table write strobe.
- key_addr  in  KA_W  key-table index 0..2R+1.
- key_wdata  in  W  expanded subkey S[key_addr].
- key_err  out  1  one-cycle pulse: key write rejected.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- in_data  in  2W  block; [W-1:0] = A, [2W-1:W] = B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  2W  result, same packing as in_data.
- out_mode  out  1  mode of the block in out_data.
- busy  out  1  high in the ROUND state.

Behaviour:
- Reset:
  - state goes to IDLE.
  - out_valid, out_data, out_mode, busy and key_err all go to 0.
  - All 2R+2 key entries are cleared to 0.
  - Round counter goes to 0.
  - Reset mid-operation aborts the block with no output.
- States:
  - IDLE: in_ready = 1.
  - ROUND: busy = 1, in_ready = 0.
  - DONE: out_valid = 1; in_ready = out_ready.
- Accept: in_valid & in_ready on a clock edge.
  - Encrypt: register A+S[0] and B+S[1].
  - Decrypt: register A and B unchanged.
  - Latch mode, set round counter i to 1 (encrypt) or R (decrypt), go to ROUND.
- Encrypt round i (one cycle):
  - A' = rotl(A^B, B[log2W-1:0]) + S[2i].
  - B' = rotl(B^A', A'[log2W-1:0]) + S[2i+1].
  - i increments.
- Decrypt round i (one cycle):
  - B' = rotr(B - S[2i+1], A[log2W-1:0]) ^ A.
  - A' = rotr(A - S[2i], B'[log2W-1:0]) ^ B'.
  - i decrements.
- Decrypt final round (i = 1): the same cycle also subtracts S[1] from B' and S[0] from A'.
- Arithmetic: all add/subtract is modulo 2^W; the rotate amount is the low log2(W) bits only.
- Completion: the edge that executes the last round loads out_data and goes to DONE.
- Latency: out_valid rises exactly R clock edges after the accepting edge.
- DONE:
  - out_data and out_mode are held stable until out_valid & out_ready.
  - On that handshake, go to IDLE if no new accept on the same edge, else to ROUND with the new block.
- Throughput: back-to-back blocks with no bubble give one block per R+1 cycles.
- Key writes:
  - Accepted only in IDLE or DONE.
  - A write in ROUND, or with key_addr > 2R+1, is dropped and key_err pulses for 1 cycle.
  - A write and an accept on the same edge: the block uses the new value (write-first).
- in_valid while not ready: ignored; the engine holds no stale state.

Decomposition:
- rc5_pkg holds:
  - state enum {IDLE, ROUND, DONE}.
  - mode constants ENC = 0, DEC = 1.
  - Parametrised rotl/rotr functions on W bits.
- Sub-module rc5_round: purely combinational single round.
  - Inputs: mode, A, B, S_even, S_odd, final_dec flag.
  - Outputs: A', B'.
  - The top level holds the key table, FSM, counter and handshakes.

Test Plan:
- W=16, R=1, S = {1,2,3,4}, encrypt in_data 0x0000_0000 -> out_data 0x800A_000F one edge after accept, out_mode = 0.
- Same key, decrypt in_data 0x800A_000F -> out_data 0x0000_0000.
- Defaults W=16, R=12, random key table:
  - 0x0000, 0xFFFF, 0xAAAA/0x5555 patterns and 100 random blocks.
  - Each is encrypted then decrypted; the decrypt result must equal the original.
  - Each out_valid must rise exactly 12 edges after accept.
- Back-pressure: hold out_ready = 0 for 20 cycles.
  - out_data stable, in_ready = 0.
  - Then out_ready = 1 together with in_valid = 1: next block accepted on the same edge, no bubble.
- Key write during ROUND -> key_err pulse, table unchanged.
- key_addr = 2R+2 in IDLE -> key_err, no write.
- Assert reset at round 5 -> next cycle out_valid = 0, busy = 0, in_ready = 1, all key entries read back as 0 through an encrypt of 0 (result 0x0000_0000).
